jk_reg_arbiter: RTL and testbench
=================================

Name: jk_reg_arbiter

Overview:
- Shared controller for a bank of WIDTH JK flip-flop bits.
- Arbitrates NREQ requesters round-robin. Each requester issues one command (hold, clear, set, toggle) on a bit mask.
- Converts the winning command into per-bit J/K drive and sequences apply/acknowledge through a 3-state FSM.
- Sits between software-visible control agents and the JK status/flag register; only this block writes the register.

Parameters:
WIDTH, 8, number of JK flip-flop bits in the managed register
NREQ, 4, number of requesters (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NREQ  request per requester, level, held until ack
cmd  input  2*NREQ  per-requester command, requester i at bits [2i+1:2i]; 00 hold, 01 clear, 10 set, 11 toggle
mask  input  WIDTH*NREQ  per-requester bit mask, requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
gnt  output  NREQ  one-hot grant, high during APPLY only
ack  output  NREQ  one-hot, single-cycle completion pulse
q  output  WIDTH  JK register contents
busy  output  1  high in APPLY and ACK

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM=IDLE, q=0, gnt=0, ack=0, busy=0.
  - Priority pointer ptr=NREQ-1, so requester 0 has highest priority first.
  - Reset asserted mid-operation aborts the operation with no q update.
- IDLE:
  - If req!=0, pick the first asserted req searching ptr+1, ptr+2, ... modulo NREQ.
  - Capture the winner index, its cmd and its mask into internal registers; go to APPLY.
  - Otherwise stay in IDLE.
- APPLY (one cycle):
  - gnt[winner]=1, busy=1.
  - J/K per bit b: if captured mask[b]=0, J=K=0. Otherwise cmd 00 gives J=0,K=0; 01 gives J=0,K=1; 10 gives J=1,K=0; 11 gives J=1,K=1.
  - Next q[b] = (J & ~q[b]) | (~K & q[b]), computed from q at the start of APPLY and registered at the closing edge.
  - ptr<=winner. Go to ACK.
- ACK (one cycle):
  - ack[winner]=1, gnt=0, busy=1; the updated q is visible. Go to IDLE.
- Latency: req seen in IDLE cycle N → gnt cycle N+1 → new q and ack cycle N+2 → IDLE cycle N+3.
- Throughput is one command per 3 cycles.
- Handshake:
  - The requester drops req in the cycle after ack.
  - A req still high when IDLE is re-entered counts as a new request. Round-robin gives all other pending requesters priority over it.
- cmd and mask are sampled only in IDLE. Changes during APPLY/ACK have no effect.
- A req deasserted during APPLY/ACK does not cancel: the operation completes and ack still pulses.
- mask=0 or cmd=00 is a legal no-op: full sequence, ack pulses, q unchanged.
- At most one gnt bit and one ack bit are ever high; gnt and ack are never high in the same cycle.
- No state other than reset produces an X on an output. Unused FSM encodings return to IDLE.

Test Plan:
- Reset: rst=0 with req=4'b1111 → q=0, gnt=0, ack=0, busy=0 for the whole reset. After release, the first grant goes to requester 0.
- Single set: WIDTH=8, req0 with cmd=10, mask=8'h0F → gnt=0001 at N+1; q=8'h0F and ack=0001 at N+2; busy high N+1..N+2.
- Toggle/clear: from q=8'h0F, req1 toggle with mask=8'hFF → q=8'hF0. Then req1 clear with mask=8'h30 → q=8'hC0.
- Round-robin contention: req=4'b1111 held, each requester dropping req after its own ack → grants in order 0,1,2,3. Requester 0 re-raising req immediately is served after 3, not before 1.
- Reset mid-op: assert rst during APPLY of a set with mask=8'hFF → q=0, no ack. After release the arbiter restarts at requester 0.
- Stability and no-op: change cmd/mask and drop req during APPLY → the originally captured command is applied and ack pulses. mask=0 command → ack pulses, q unchanged.

Source files
------------

// File: rtl/jk_reg_arbiter.sv
// Round-robin arbiter that owns a bank of JK flip-flop bits: one requester's
// hold/clear/set/toggle command is applied per IDLE -> APPLY -> ACK sequence.
module jk_reg_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     cmd,
   input  logic [WIDTH*NREQ-1:0] mask,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      q,
   output logic                  busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      APPLY = 2'b01,
      ACK   = 2'b10
   } state_t;

   state_t           state, state_nxt;
   logic [PW-1:0]    ptr, win, pick, cand;
   logic             found;
   logic [1:0]       wcmd;
   logic [WIDTH-1:0] wmask, j, k;
   logic [NREQ-1:0]  win_oh;
   int unsigned      idx;

   // Search starts just after the last winner, so the last winner ranks lowest.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment;
      // a path that leaves one unassigned would infer a latch.
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      idx   = 0;
      for (int i = 1; i <= NREQ; i++) begin
         idx  = (int'(ptr) + i) % NREQ;
         cand = PW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
   assign j      = wmask & {WIDTH{wcmd[1]}};
   assign k      = wmask & {WIDTH{wcmd[0]}};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      ack       = '0;
      busy      = 1'b0;
      case (state)
         IDLE:  if (found) state_nxt = APPLY;
         APPLY: begin
            state_nxt = ACK;
            gnt       = win_oh;
            busy      = 1'b1;
         end
         ACK: begin
            state_nxt = IDLE;
            ack       = win_oh;
            busy      = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cmd/mask are captured once in IDLE, so later changes by the requester are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr   <= PW'(NREQ-1);
         win   <= '0;
         wcmd  <= '0;
         wmask <= '0;
         q     <= '0;
      end else begin
         if (state == IDLE && found) begin
            win   <= pick;
            wcmd  <= cmd[2*pick +: 2];
            wmask <= mask[WIDTH*pick +: WIDTH];
         end
         if (state == APPLY) begin
            q   <= (j & ~q) | (~k & q);
            ptr <= win;
         end
      end
   end

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// Self-checking bench for jk_reg_arbiter: directed scenarios with literal
// expectations plus randomized requesters, all compared against a transaction model.
module tb_jk_reg_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req = '0;
   logic [2*N-1:0] cmd = '0;
   logic [W*N-1:0] mask = '0;
   logic [N-1:0]   gnt, ack;
   logic [W-1:0]   q;
   logic           busy;

   int n_cmp = 0;
   int n_err = 0;

   jk_reg_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst(rst), .req(req), .cmd(cmd), .mask(mask),
      .gnt(gnt), .ack(ack), .q(q), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 waiting, 1 command in flight, 2 completing.
   int           m_phase, m_win, m_ptr, m_c;
   logic [1:0]   m_cmd;
   logic [W-1:0] m_mask, m_q;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase = 0;
         m_ptr   = N-1;
         m_win   = 0;
         m_q     = '0;
      end else begin
         case (m_phase)
            0: begin
               for (int s = 1; s <= N; s++) begin
                  m_c = (m_ptr + s) % N;
                  if (req[m_c]) begin
                     m_win   = m_c;
                     m_cmd   = cmd[2*m_c +: 2];
                     m_mask  = mask[W*m_c +: W];
                     m_phase = 1;
                     break;
                  end
               end
            end
            1: begin
               for (int b = 0; b < W; b++)
                  if (m_mask[b])
                     case (m_cmd)
                        2'b01:   m_q[b] = 1'b0;
                        2'b10:   m_q[b] = 1'b1;
                        2'b11:   m_q[b] = ~m_q[b];
                        default: m_q[b] = m_q[b];
                     endcase
               m_ptr   = m_win;
               m_phase = 2;
            end
            default: m_phase = 0;
         endcase
      end
   end

   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("gnt",  gnt,  (m_phase == 1) ? (32'd1 << m_win) : 32'd0);
         check("ack",  ack,  (m_phase == 2) ? (32'd1 << m_win) : 32'd0);
         check("busy", busy, (m_phase != 0) ? 32'd1 : 32'd0);
         check("q",    q,    m_q);
      end
   end

   bit log_en = 0;
   int gnt_log[$];
   always @(negedge clk) begin
      if (log_en)
         for (int i = 0; i < N; i++)
            if (gnt[i]) gnt_log.push_back(i);
   end

   task automatic wait_ack(input int i);
      bit ok = 0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge clk);
         if (ack[i]) ok = 1;
      end
      check($sformatf("ack%0d_seen", i), ok, 1);
   endtask

   task automatic wait_gnt(input int i);
      bit ok = 0;
      for (int c = 0; c < 30 && !ok; c++) begin
         @(negedge clk);
         if (gnt[i]) ok = 1;
      end
      check($sformatf("gnt%0d_seen", i), ok, 1);
   endtask

   task automatic run_cmd(input int i, input logic [1:0] c, input logic [W-1:0] m,
                          input logic [W-1:0] exp_q);
      cmd[2*i +: 2]  = c;
      mask[W*i +: W] = m;
      req[i]         = 1'b1;
      wait_ack(i);
      check("run_cmd_q", q, exp_q);
      req[i] = 1'b0;
   endtask

   initial begin
      bit rearmed = 0;

      // Reset held with every requester asking.
      rst  = 1'b0;
      req  = 4'b1111;
      cmd  = 8'b10_10_10_10;
      mask = {8'h08, 8'h04, 8'h02, 8'h01};
      @(posedge clk);
      chk_en = 1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_q", q, 0);
         check("rst_gnt", gnt, 0);
         check("rst_ack", ack, 0);
         check("rst_busy", busy, 0);
      end
      log_en = 1;
      rst    = 1'b1;
      @(negedge clk);
      check("first_gnt", gnt, 4'b0001);

      // Contention: everyone drops after its ack; requester 0 re-raises at once.
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         if (!req[0] && !rearmed) begin
            req[0]  = 1'b1;
            rearmed = 1;
         end
         for (int i = 0; i < N; i++)
            if (ack[i]) req[i] = 1'b0;
      end
      log_en = 0;
      check("rr_count", gnt_log.size(), 5);
      for (int t = 0; t < 5 && t < gnt_log.size(); t++)
         check($sformatf("rr_order%0d", t), gnt_log[t], t % 4);
      check("rr_q", q, 8'h0F);

      // Reset during APPLY of a full-width set aborts it.
      req = '0;
      cmd[3:2]   = 2'b10;
      mask[15:8] = 8'hFF;
      req[1]     = 1'b1;
      wait_gnt(1);
      #2 rst = 1'b0;
      #1;
      check("abort_q", q, 0);
      check("abort_gnt", gnt, 0);
      check("abort_busy", busy, 0);
      @(negedge clk);
      check("abort_ack", ack, 0);
      req        = 4'b0011;
      cmd[1:0]   = 2'b10;  mask[7:0]  = 8'h0F;
      cmd[3:2]   = 2'b11;  mask[15:8] = 8'hFF;
      rst        = 1'b1;

      // Single set with exact latency, then toggle with stability of captured command.
      @(negedge clk);
      check("set_gnt", gnt, 4'b0001);
      check("set_busy1", busy, 1);
      @(negedge clk);
      check("set_ack", ack, 4'b0001);
      check("set_q", q, 8'h0F);
      check("set_busy2", busy, 1);
      req[0] = 1'b0;
      @(negedge clk);
      check("set_idle_busy", busy, 0);
      check("set_idle_gnt", gnt, 0);
      @(negedge clk);
      check("tog_gnt", gnt, 4'b0010);
      cmd[3:2]   = 2'b00;
      mask[15:8] = 8'h00;
      req[1]     = 1'b0;
      @(negedge clk);
      check("tog_ack", ack, 4'b0010);
      check("tog_q", q, 8'hF0);
      @(negedge clk);
      check("tog_idle_busy", busy, 0);

      run_cmd(1, 2'b01, 8'h30, 8'hC0);
      run_cmd(2, 2'b11, 8'h00, 8'hC0);
      run_cmd(3, 2'b00, 8'hFF, 8'hC0);

      // Randomized requesters checked against the model every cycle.
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (gnt[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  cmd[2*i +: 2]  = 2'($urandom_range(0, 3));
                  mask[W*i +: W] = W'($urandom_range(0, 255));
               end
               if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               cmd[2*i +: 2]  = 2'($urandom_range(0, 3));
               mask[W*i +: W] = W'($urandom_range(0, 255));
               req[i]         = 1'b1;
            end
         end
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
